// File: rtl/forward_control_unit.sv
// Forwarding and load-use hazard control for a 5-stage pipeline.
// Tracks EX/MEM/WB destination info and drives the EX operand mux selects and the stall request.
module forward_control_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_write_reg,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      flush,
  output logic [1:0]                forward_a,
  output logic [1:0]                forward_b,
  output logic                      stall,
  output logic [CNT_WIDTH-1:0]      stall_count
);

  typedef logic [REG_ADDR_WIDTH-1:0] reg_t;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    reg_t dest;
  } stg_t;

  typedef struct packed {
    stg_t s;
    reg_t rs;
    reg_t rt;
  } ex_t;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_WB  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;

  ex_t  ex_q, ex_d;
  stg_t mem_q, mem_d;
  stg_t wb_q, wb_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  // A load in MEM has no ALU result to forward; fall through to the WB check.
  function automatic logic [1:0] fwd_sel(input reg_t src);
    if (mem_q.valid && mem_q.reg_write && !mem_q.mem_read &&
        mem_q.dest != '0 && mem_q.dest == src)
      return SEL_MEM;
    else if (wb_q.valid && wb_q.reg_write && wb_q.dest != '0 && wb_q.dest == src)
      return SEL_WB;
    else
      return SEL_RF;
  endfunction

  always_comb begin
    forward_a = fwd_sel(ex_q.rs);
    forward_b = fwd_sel(ex_q.rt);
    stall = !flush && id_valid && ex_q.s.valid && ex_q.s.mem_read &&
            ex_q.s.dest != '0 && (ex_q.s.dest == id_rs || ex_q.s.dest == id_rt);
  end

  always_comb begin
    ex_d  = '0;
    mem_d = ex_q.s;
    wb_d  = mem_q;
    if (id_valid && !stall && !flush) begin
      ex_d.s.valid     = 1'b1;
      ex_d.s.reg_write = id_reg_write;
      ex_d.s.mem_read  = id_mem_read;
      ex_d.s.dest      = id_write_reg;
      ex_d.rs          = id_rs;
      ex_d.rt          = id_rt;
    end
    stall_count_d = stall_count_q;
    if (stall && stall_count_q != '1)
      stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_forward_control_unit.sv
// Directed checks of forwarding selects, load-use stall, flush, and the saturating stall counter.
module tb_forward_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_write_reg;
  logic       id_reg_write, id_mem_read, flush;
  logic [1:0] forward_a, forward_b, forward_a2, forward_b2;
  logic       stall, stall2;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  forward_control_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_write_reg(id_write_reg), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .forward_a(forward_a), .forward_b(forward_b), .stall(stall),
    .stall_count(stall_count)
  );

  // Narrow counter copy to exercise saturation.
  forward_control_unit #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_write_reg(id_write_reg), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .forward_a(forward_a2), .forward_b(forward_b2), .stall(stall2),
    .stall_count(stall_count2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present an instruction in ID; outputs are sampled 1ns later.
  task automatic issue(input logic v, input int rs, input int rt, input int wr,
                       input logic rw, input logic mr);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_write_reg = 5'(wr);
    id_reg_write = rw; id_mem_read = mr;
    #1;
  endtask

  task automatic idle();
    issue(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0;
    idle();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0;
    @(negedge clk);
    do_reset();
    chk("rst_fa", forward_a, 0);
    chk("rst_fb", forward_b, 0);
    chk("rst_stall", stall, 0);
    chk("rst_cnt", stall_count, 0);

    // add $3,$1,$2 ; sub $4,$3,$5 -> EX/MEM forward on A
    issue(1, 1, 2, 3, 1, 0); tick();
    issue(1, 3, 5, 4, 1, 0);
    chk("exmem_nostall", stall, 0);
    tick(); idle();
    chk("exmem_fa", forward_a, 2);
    chk("exmem_fb", forward_b, 0);

    // add $3 ; nop ; or $6,$5,$3 -> MEM/WB forward on B
    do_reset();
    issue(1, 1, 2, 3, 1, 0); tick();
    idle(); tick();
    issue(1, 5, 3, 6, 1, 0); tick(); idle();
    chk("memwb_fa", forward_a, 0);
    chk("memwb_fb", forward_b, 1);

    // lw $2 ; add $7,$2,$2 -> one stall, then WB forwarding after the bubble
    do_reset();
    issue(1, 1, 0, 2, 1, 1); tick();
    issue(1, 2, 2, 7, 1, 0);
    chk("lu_stall", stall, 1);
    chk("lu_cnt0", stall_count, 0);
    tick();
    chk("lu_cnt1", stall_count, 1);
    chk("lu_stall_clear", stall, 0);
    tick(); idle();
    chk("lu_fa", forward_a, 1);
    chk("lu_fb", forward_b, 1);
    chk("lu_cnt_hold", stall_count, 1);

    // $0 never forwards or stalls
    do_reset();
    issue(1, 1, 2, 0, 1, 0); tick();
    issue(1, 0, 0, 5, 1, 0); tick(); idle();
    chk("r0_fa", forward_a, 0);
    chk("r0_fb", forward_b, 0);
    issue(1, 1, 1, 0, 1, 1); tick();
    issue(1, 0, 0, 5, 1, 0);
    chk("r0_lw_stall", stall, 0);

    // add $3 (WB) and addi $3 (MEM) -> MEM wins
    do_reset();
    issue(1, 1, 2, 3, 1, 0); tick();
    issue(1, 3, 0, 3, 1, 0); tick();
    issue(1, 3, 3, 8, 1, 0); tick(); idle();
    chk("prio_fa", forward_a, 2);
    chk("prio_fb", forward_b, 2);

    // flush overrides a load-use stall and squashes the slot
    do_reset();
    issue(1, 1, 0, 2, 1, 1); tick();
    flush = 1'b1;
    issue(1, 2, 4, 9, 1, 0);
    chk("flush_stall", stall, 0);
    tick(); flush = 1'b0;
    issue(1, 9, 9, 10, 1, 0);
    chk("flush_no_fwd_squashed", forward_a, 0);
    chk("flush_cnt", stall_count, 0);
    tick(); idle();
    chk("flush_fa_bubble_ex", forward_a, 0);

    // Saturation on the 2-bit counter, then reset mid-stall
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(1, 1, 0, 2, 1, 1); tick();
      issue(1, 2, 3, 7, 1, 0);
      chk($sformatf("sat_stall%0d", i), stall2, 1);
      tick(); idle(); tick();
    end
    chk("sat_cnt2", stall_count2, 3);
    chk("sat_cnt16", stall_count, 4);
    issue(1, 1, 0, 2, 1, 1); tick();
    issue(1, 2, 3, 7, 1, 0);
    chk("mid_stall", stall2, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("mid_rst_cnt2", stall_count2, 0);
    chk("mid_rst_cnt16", stall_count, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_fa", forward_a, 0);
    chk("mid_rst_fb", forward_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/forward_control_unit.md
FORWARD_CONTROL_UNIT -- requirements
Module: forward_control_unit

Interface
REQ-001 The block SHALL have parameter REG_ADDR_WIDTH, default 5, giving the register-index width.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, giving the stall-counter width.
REQ-003 The block SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have reset, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have id_valid, input, 1, meaning the ID-stage slot holds a real instruction.
REQ-006 The block SHALL have id_rs and id_rt, inputs, REG_ADDR_WIDTH each, the ID-stage source register indices.
REQ-007 The block SHALL have id_write_reg, input, REG_ADDR_WIDTH, the ID-stage destination index.
REQ-008 The block SHALL have id_reg_write and id_mem_read, inputs, 1 each, the ID-stage decoded controls.
REQ-009 The block SHALL have flush, input, 1, a branch/jump squash of the ID-stage slot.
REQ-010 The block SHALL have forward_a and forward_b, outputs, 2 each, the selectors for the EX operand A/B 3-to-1 muxes.
REQ-011 The block SHALL have stall, output, 1, a request to hold PC and the IF/ID register.
REQ-012 The block SHALL have stall_count, output, CNT_WIDTH, the number of stall cycles since reset.

Function
REQ-013 The block SHALL track three stage slots (EX, MEM, WB), each holding valid, reg_write, mem_read and dest; the EX slot also holds rs and rt.
REQ-014 On each clock, WB SHALL take MEM's contents, and MEM SHALL take EX's contents.
REQ-015 On each clock, EX SHALL load the ID inputs, or a bubble (all fields 0) when stall, flush or !id_valid is true.
REQ-016 Selector encoding SHALL be: 0 = register-file operand, 1 = MEM/WB writeback value, 2 = EX/MEM ALU result; code 3 SHALL never be driven.
REQ-017 forward_a SHALL be 2 when MEM.valid, MEM.reg_write and !MEM.mem_read are all true, MEM.dest != 0, and MEM.dest == EX.rs.
REQ-018 Otherwise, forward_a SHALL be 1 when WB.valid and WB.reg_write are true, WB.dest != 0, and WB.dest == EX.rs; otherwise 0.
REQ-019 forward_b SHALL follow REQ-017/018 using EX.rt in place of EX.rs.
REQ-020 A MEM-stage match SHALL take priority over a simultaneous WB-stage match, because it is the newer value.
REQ-021 A MEM-stage load match (mem_read=1) SHALL NOT select 2; evaluation then falls through to the WB check.
REQ-022 stall SHALL be 1 when id_valid=1, EX.valid=1, EX.mem_read=1, EX.dest != 0, and EX.dest equals id_rs or id_rt.
REQ-023 stall SHALL last exactly one cycle per load-use pair: the inserted bubble clears the condition on the next cycle.
REQ-024 When flush=1, stall SHALL be forced to 0 and the ID slot SHALL be squashed.
REQ-025 Register index 0 SHALL never cause forwarding or a stall.
REQ-026 forward_a, forward_b and stall SHALL be combinational from the stage registers and ID inputs, with zero added latency.
REQ-027 stall_count SHALL increment by 1 on every clock where stall=1 and SHALL saturate at all-ones with no wrap.

Reset
REQ-028 While reset=1 at a clock edge, every slot SHALL clear to all-zero (invalid) and stall_count SHALL clear to 0.
REQ-029 After reset, forward_a=0, forward_b=0 and stall=0 SHALL hold until valid instructions enter.
REQ-030 Reset SHALL take priority over stall and flush, and reset asserted mid-stall SHALL discard the pending hazard.

Verification
REQ-031 Issue add $3 then sub $4,$3,$5 back-to-back -> with sub in EX: forward_a=2, forward_b=0, stall=0.
REQ-032 Issue add $3, a nop, then or $6,$5,$3 -> with or in EX: forward_b=1, forward_a=0.
REQ-033 Issue lw $2 then add $7,$2,$2 -> stall=1 for one cycle and stall_count goes 0->1; after the bubble, forward_a=forward_b=1.
REQ-034 Issue add $0 then a consumer of $0 -> forward_a=forward_b=0 and stall=0.
REQ-035 Issue add $3 (now in WB) and addi $3 (now in MEM), with a consumer of $3 in EX -> forward_a=2 (MEM wins).
REQ-036 Hold the load-use condition with CNT_WIDTH=2, then pulse reset mid-stall -> the count stops at 3 with no wrap, and reset returns all outputs to 0 on the next edge.
